// File: rtl/mac_pkg.sv
// Shared types and sizing helpers for the sequential multiply-accumulate block.
// State encoding and slice-select width derivation used by mac_seq_acc and its core.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ACC  = 2'd2
    } state_e;

    // Slice-select width; at least one bit even for a single-slice accumulator.
    function automatic int calc_sel_w(input int acc_w, input int out_w);
        int nslice;
        nslice = acc_w / out_w;
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/mac_shift_add_mul.sv
// Shift-add unsigned multiplier core: one multiplier bit per step cycle.
// Latency: DATA_W step cycles after start; finish is high on the last step.
// Backpressure: none; the caller sequences start/step.
module mac_shift_add_mul
    import mac_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  step,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic [2*DATA_W-1:0]   prod,
    output logic                  finish
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [2*DATA_W-1:0] mcand;
    logic [DATA_W-1:0]   mplr;
    logic [CNT_W-1:0]    cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand <= '0;
            mplr  <= '0;
            prod  <= '0;
            cnt   <= '0;
        end else if (start) begin
            mcand <= {{DATA_W{1'b0}}, a};
            mplr  <= b;
            prod  <= '0;
            cnt   <= '0;
        end else if (step) begin
            if (mplr[0]) begin
                prod <= prod + mcand;
            end
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
            cnt   <= cnt + 1'b1;
        end
    end

    // Fixed latency: no early exit when the remaining multiplier bits are zero.
    assign finish = step && (cnt == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/mac_seq_acc.sv
// Sequential MAC: shift-add multiply then accumulate into a sliced accumulator; MAC_SATURATE_EN clamps on overflow.
// Latency: DATA_W+1 edges from accept to accumulator update, done pulses the cycle after.
// Backpressure: in_ready only in IDLE; one operation per DATA_W+2 cycles.
module mac_seq_acc
    import mac_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int ACC_W  = 24,
    parameter  int OUT_W  = 8,
    localparam int NSLICE = ACC_W / OUT_W,
    localparam int SEL_W  = calc_sel_w(ACC_W, OUT_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              acc_clr,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    input  logic [SEL_W-1:0]  sel,
    output logic [OUT_W-1:0]  slice_out,
    input  logic              ld_en,
    input  logic [OUT_W-1:0]  ld_data
);

    state_e              state;
    state_e              state_nxt;
    logic                accept;
    logic                mul_finish;
    logic [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W:0]      sum;
    logic [ACC_W-1:0]    acc_sum;
    logic [ACC_W-1:0]    acc_ld;
    logic                ld_hit;

    assign in_ready = (state == IDLE);
    assign busy     = (state == MUL) || (state == ACC);
    assign accept   = in_valid && in_ready;

    mac_shift_add_mul #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept),
        .step   (state == MUL),
        .a      (in_a),
        .b      (in_b),
        .prod   (prod),
        .finish (mul_finish)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = MUL;
            MUL:     if (mul_finish) state_nxt = ACC;
            ACC:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign sum = {1'b0, acc} + {{(ACC_W + 1 - 2*DATA_W){1'b0}}, prod};

`ifdef MAC_SATURATE_EN
    assign acc_sum = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    assign acc_sum = sum[ACC_W-1:0];
`endif

    // Out-of-range selects match no slice, so the load and the readout both fall away.
    always_comb begin
        acc_ld    = acc;
        ld_hit    = 1'b0;
        slice_out = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (sel == SEL_W'(i)) begin
                acc_ld[i*OUT_W +: OUT_W] = ld_data;
                ld_hit                   = 1'b1;
                slice_out                = acc[i*OUT_W +: OUT_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state == ACC);
        end
    end

    // Clear beats accumulate beats load; a clear on the ACC edge drops the product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (acc_clr) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (state == ACC) begin
            acc <= acc_sum;
            if (sum[ACC_W]) begin
                ovf <= 1'b1;
            end
        end else if (ld_en && ld_hit && (state == IDLE)) begin
            acc <= acc_ld;
        end
    end

endmodule

// File: tb/tb_mac_seq_acc.sv
// Directed bench for mac_seq_acc with default 8/24/8 parameters.
module tb_mac_seq_acc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;
    logic        acc_clr = 1'b0;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [1:0]  sel = '0;
    logic [7:0]  slice_out;
    logic        ld_en = 1'b0;
    logic [7:0]  ld_data = '0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [23:0] exp_acc;
    } vec_t;

    vec_t vecs[3];

    mac_seq_acc #(.DATA_W(8), .ACC_W(24), .OUT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .acc_clr   (acc_clr),
        .busy      (busy),
        .done      (done),
        .ovf       (ovf),
        .sel       (sel),
        .slice_out (slice_out),
        .ld_en     (ld_en),
        .ld_data   (ld_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called in the low clock phase; walks sel over the three slices.
    task automatic read_acc(output logic [23:0] v);
        v = '0;
        for (int i = 0; i < 3; i++) begin
            sel = 2'(i);
            #1;
            v[i*8 +: 8] = slice_out;
        end
        sel = 2'd0;
        #1;
    endtask

    task automatic start_op(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int start_cnt, output int lat);
        lat = start_cnt;
        while (lat < 30) begin
            @(posedge clk);
            lat++;
            #1;
            if (done) break;
        end
    endtask

    task automatic do_op(input logic [7:0] a, input logic [7:0] b, output int lat);
        start_op(a, b);
        wait_done(0, lat);
    endtask

    task automatic load_slice(input logic [1:0] s, input logic [7:0] d);
        @(negedge clk);
        ld_en = 1'b1;
        sel = s;
        ld_data = d;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
        sel = 2'd0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        acc_clr = 1'b1;
        @(posedge clk);
        #1;
        acc_clr = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        logic [23:0] v;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_busy"},     32'(busy),     32'd0);
        check({tag, "_done"},     32'(done),     32'd0);
        check({tag, "_ovf"},      32'(ovf),      32'd0);
        read_acc(v);
        check({tag, "_acc"},      32'(v),        32'h0);
    endtask

    initial begin
        logic [23:0] v;
        int          lat;

        vecs[0] = '{a: 8'd3,   b: 8'd4, exp_acc: 24'h00000C};
        vecs[1] = '{a: 8'd2,   b: 8'd5, exp_acc: 24'h000016};
        vecs[2] = '{a: 8'd100, b: 8'd2, exp_acc: 24'h0000DE};

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            do_op(vecs[i].a, vecs[i].b, lat);
            check($sformatf("op%0d_done_latency", i), 32'(lat), 32'd9);
            check($sformatf("op%0d_in_ready_at_done", i), 32'(in_ready), 32'd1);
            @(negedge clk);
            read_acc(v);
            check($sformatf("op%0d_acc", i), 32'(v), 32'(vecs[i].exp_acc));
        end

        @(negedge clk);
        sel = 2'd0; #1;
        check("slice0_read", 32'(slice_out), 32'hDE);
        sel = 2'd1; #1;
        check("slice1_read", 32'(slice_out), 32'h00);
        sel = 2'd3; #1;
        check("slice_oob_read", 32'(slice_out), 32'h00);
        sel = 2'd0;

        // Slice load in IDLE, visible the cycle after its edge.
        @(negedge clk);
        ld_en = 1'b1; sel = 2'd1; ld_data = 8'hAA;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
        check("ld_slice1_next_cycle", 32'(slice_out), 32'hAA);
        @(negedge clk);
        read_acc(v);
        check("ld_acc", 32'(v), 32'h00AADE);

        // Load attempted during MUL must be ignored.
        start_op(8'd0, 8'd0);
        @(posedge clk);
        #1;
        ld_en = 1'b1; sel = 2'd2; ld_data = 8'h55;
        check("busy_in_mul", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        ld_en = 1'b0; sel = 2'd0;
        wait_done(2, lat);
        check("ld_in_mul_latency", 32'(lat), 32'd9);
        @(negedge clk);
        read_acc(v);
        check("ld_in_mul_ignored", 32'(v), 32'h00AADE);

        // Overflow on 0xFFFFFF + 1.
        load_slice(2'd0, 8'hFF);
        load_slice(2'd1, 8'hFF);
        load_slice(2'd2, 8'hFF);
        @(negedge clk);
        read_acc(v);
        check("ovf_preload", 32'(v), 32'hFFFFFF);
        check("ovf_before", 32'(ovf), 32'd0);
        do_op(8'd1, 8'd1, lat);
        @(negedge clk);
        read_acc(v);
`ifdef MAC_SATURATE_EN
        check("ovf_acc_sat", 32'(v), 32'hFFFFFF);
`else
        check("ovf_acc_wrap", 32'(v), 32'h000000);
`endif
        check("ovf_set", 32'(ovf), 32'd1);
        pulse_clr();
        @(negedge clk);
        check("ovf_cleared", 32'(ovf), 32'd0);
        read_acc(v);
        check("clr_acc", 32'(v), 32'h0);

        // Out-of-range load select leaves the accumulator alone.
        load_slice(2'd3, 8'h77);
        @(negedge clk);
        read_acc(v);
        check("ld_oob_ignored", 32'(v), 32'h0);

        // Clear mid-flight: product lands on the cleared accumulator.
        load_slice(2'd0, 8'h34);
        load_slice(2'd1, 8'h12);
        @(negedge clk);
        read_acc(v);
        check("midclr_preload", 32'(v), 32'h001234);
        start_op(8'd255, 8'd255);
        @(posedge clk); #1;
        @(posedge clk); #1;
        acc_clr = 1'b1;
        @(posedge clk); #1;
        acc_clr = 1'b0;
        check("midclr_acc_zero", 32'(slice_out), 32'h0);
        wait_done(3, lat);
        check("midclr_latency", 32'(lat), 32'd9);
        @(negedge clk);
        read_acc(v);
        check("midclr_acc", 32'(v), 32'h00FE01);
        check("midclr_ovf", 32'(ovf), 32'd0);

        // Back-to-back with in_valid held high.
        pulse_clr();
        @(negedge clk);
        in_a = 8'd255; in_b = 8'd255; in_valid = 1'b1;
        @(posedge clk); #1;
        check("b2b_ready_low", 32'(in_ready), 32'd0);
        check("b2b_busy", 32'(busy), 32'd1);
        wait_done(0, lat);
        check("b2b_first_latency", 32'(lat), 32'd9);
        check("b2b_ready_at_done", 32'(in_ready), 32'd1);
        check("b2b_busy_at_done", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("b2b_second_accept", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        wait_done(0, lat);
        check("b2b_second_latency", 32'(lat), 32'd9);
        @(negedge clk);
        read_acc(v);
        check("b2b_acc", 32'(v), 32'h01FC02);

        // Reset in the middle of MUL, then a clean operation.
        start_op(8'd200, 8'd200);
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        do_op(8'd7, 8'd6, lat);
        check("post_rst_latency", 32'(lat), 32'd9);
        @(negedge clk);
        read_acc(v);
        check("post_rst_acc", 32'(v), 32'h00002A);
        check("post_rst_ovf", 32'(ovf), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_seq_acc.md
# mac_seq_acc

Parametrised sequential multiply-accumulate block, the next generation of the tiny 8x8 MAC. It multiplies unsigned operands with a shift-add datapath over DATA_W cycles under a valid/ready handshake and adds the product into a wide accumulator. The accumulator is read and written as OUT_W-bit slices through a selectable window, and a sticky overflow flag is kept. It sits between a byte-wide pad interface and the surrounding control logic.

## Interface
- DATA_W, 8, operand width
- ACC_W, 24, accumulator width; must be ≥ 2·DATA_W and a multiple of OUT_W
- OUT_W, 8, slice width for readout/load; NSLICE = ACC_W/OUT_W, SEL_W = max(1, $clog2(NSLICE))
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands (state IDLE)
- in_a  in  DATA_W  multiplicand, unsigned
- in_b  in  DATA_W  multiplier, unsigned
- acc_clr  in  1  synchronous clear of accumulator and ovf
- busy  out  1  operation in flight (MUL or ACC)
- done  out  1  one-cycle pulse: accumulator just updated
- ovf  out  1  sticky overflow flag
- sel  in  SEL_W  slice select
- slice_out  out  OUT_W  acc[sel·OUT_W +: OUT_W]; 0 if sel ≥ NSLICE
- ld_en  in  1  load ld_data into selected slice
- ld_data  in  OUT_W  slice load value

## Operation
- States: IDLE → MUL → ACC → IDLE.
- IDLE: in_ready=1. On in_valid: latch in_a zero-extended to 2·DATA_W into mcand, in_b into mplr, prod=0, cnt=0; go to MUL.
- MUL: each cycle, if mplr[0] then prod += mcand; mcand <<= 1; mplr >>= 1; cnt++. After DATA_W cycles go to ACC. Latency is fixed; there is no early exit on zero.
- ACC: sum = acc + zero-extended prod, computed at ACC_W+1 bits. On carry, set ovf; acc takes the wrapped sum. Assert done next cycle and return to IDLE.
- Priority at each edge: acc_clr > accumulate > ld_en.
  - acc_clr, any state: acc=0, ovf=0. An in-flight operation continues, and its product lands on the cleared accumulator unless clr coincides with the ACC edge, in which case clr wins and the product is dropped.
  - ld_en is honoured only in IDLE. It is ignored when sel ≥ NSLICE and does not affect ovf.
- ld_en and the in_valid handshake in the same IDLE cycle: both take effect.
- slice_out is combinational from the registered acc.
- Reset values: acc=0, ovf=0, done=0, busy=0, in_ready=1, slice_out=0, state IDLE.
- Reset mid-operation aborts immediately with no partial accumulate.

## Timing
- E0 = edge where in_valid && in_ready. MUL occupies edges E1..E_DATA_W. The ACC edge E_(DATA_W+1) writes acc.
- done=1, busy=0 and in_ready=1 hold during the cycle after E_(DATA_W+1).
- Throughput: one operation per DATA_W+2 cycles with in_valid held high.
- An ld_en write is visible on slice_out the cycle after its edge.

## Configuration
- MAC_SATURATE_EN defined: on carry out of ACC_W, acc clamps to all-ones and ovf is set.
- Not defined: acc wraps modulo 2^ACC_W and ovf is set.
- Handshake, latency and all other behaviour are identical in both builds.

## Structure
- Package mac_pkg holds:
  - state enum (IDLE, MUL, ACC)
  - helper function computing SEL_W from ACC_W/OUT_W
- Sub-module mac_shift_add_mul holds the shift-add core: mcand, mplr, prod, cnt, start/finish strobes.
- The top level holds the FSM, accumulator, overflow/saturation, slice mux and load.

## Test plan
All scenarios use defaults (8/24/8).
- Accumulate: rst_n pulse; ops 3×4, 2×5, 100×2 → acc=0x0000DE. sel=0 reads 0xDE, sel=1 reads 0x00. done pulses 9 edges after each handshake edge.
- Slice load: in IDLE, ld_en, sel=1, ld_data=0xAA → acc=0x00AADE; slice_out with sel=1 reads 0xAA next cycle. ld_en during MUL → acc unchanged.
- Overflow: load 0xFF into slices 0..2, then 1×1.
  - Wrap build: acc=0x000000, ovf=1.
  - MAC_SATURATE_EN build: acc=0xFFFFFF, ovf=1.
  - acc_clr afterwards → ovf=0.
- Clear mid-flight: acc=0x1234, start 255×255, acc_clr on E3 → final acc=0x00FE01, ovf=0.
- Back-to-back: in_valid held with 255×255 twice → in_ready low during busy; second accept on the cycle done=1; acc=0x01FC02.
- Reset mid-MUL: rst_n low on cycle E4 → all outputs at reset values. A following 7×6 gives acc=0x00002A.
